// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and sizes for the register-file writeback controller.
package regfile_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Which path produced the write currently held in the output register.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Long-latency (source B) writeback handshake into the controller.
interface regfile_wb_ctrl_if;
    import regfile_pkg::*;

    logic            i_b_valid;
    logic            o_b_ready;
    logic [AW-1:0]   i_b_rd;
    logic [XLEN-1:0] i_b_data;

    modport master (output i_b_valid, i_b_rd, i_b_data, input o_b_ready);
    modport slave  (input i_b_valid, i_b_rd, i_b_data, output o_b_ready);

endinterface

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Source-B result FIFO: DEPTH x wb_req_t with a registered not-full flag.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  wb_req_t                  i_req,
    input  logic                     i_pop,
    output wb_req_t                  o_head,
    output logic                     o_full,
    output logic                     o_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q;
    logic            do_push, do_pop;

    assign do_pop  = i_pop && (count_q != '0);
    assign do_push = i_push && (count_q != CW'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Ready looks at the next count so it never depends combinationally on i_push.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_req;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_ready = ready_q;
    assign o_count = count_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Merges ALU (A) and long-latency (B) writebacks onto the single regfile write port
// and tracks in-flight B destinations for decode stalls.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned B_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_a_valid,
    input  logic [AW-1:0]     i_a_rd,
    input  logic [XLEN-1:0]   i_a_data,
    regfile_wb_ctrl_if.slave  b_if,
    input  logic              i_issue_valid,
    input  logic [AW-1:0]     i_issue_rd,
    input  logic [AW-1:0]     i_rs1_addr,
    input  logic [AW-1:0]     i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_rd_wren,
    output logic [AW-1:0]     o_rd_addr,
    output logic [XLEN-1:0]   o_rd_data
);

    wb_req_t                    fifo_head;
    wb_req_t                    fifo_req;
    logic                       fifo_full;
    logic                       fifo_ready;
    logic [$clog2(B_DEPTH):0]   fifo_count;
    logic                       fifo_push;
    logic                       fifo_pop;

    logic                       wren_q, wren_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [XLEN-1:0]            data_q, data_d;
    wb_src_t                    src_q, src_d;
    logic [NREGS-1:0]           sb_q, sb_d;
    logic                       b_on_port;

    assign fifo_req.rd   = b_if.i_b_rd;
    assign fifo_req.data = b_if.i_b_data;
    assign fifo_push     = b_if.i_b_valid && fifo_ready && !fifo_full;
    assign b_if.o_b_ready = fifo_ready;

    wb_fifo #(
        .DEPTH (B_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (fifo_push),
        .i_req   (fifo_req),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_ready (fifo_ready),
        .o_count (fifo_count)
    );

    // A always wins; x0 writes still consume their slot (B is popped) but never assert wren.
    always_comb begin
        fifo_pop = 1'b0;
        wren_d   = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        src_d    = SRC_A;
        if (i_a_valid) begin
            if (i_a_rd != '0) begin
                wren_d = 1'b1;
                addr_d = i_a_rd;
                data_d = i_a_data;
            end
        end else if (fifo_count != '0) begin
            fifo_pop = 1'b1;
            src_d    = SRC_B;
            if (fifo_head.rd != '0) begin
                wren_d = 1'b1;
                addr_d = fifo_head.rd;
                data_d = fifo_head.data;
            end
        end
    end

    assign b_on_port = wren_q && (src_q == SRC_B);

    // Clear on the edge that commits the B write, then apply a same-edge issue so it wins.
    always_comb begin
        sb_d = sb_q;
        if (b_on_port) begin
            sb_d[addr_q] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != '0)) begin
            sb_d[i_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= SRC_A;
            sb_q   <= '0;
        end else begin
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
            sb_q   <= sb_d;
        end
    end

    assign o_rd_wren = wren_q;
    assign o_rd_addr = addr_q;
    assign o_rd_data = data_q;

    assign o_rs1_busy = (i_rs1_addr != '0) &&
                        (sb_q[i_rs1_addr] || (b_on_port && (addr_q == i_rs1_addr)));
    assign o_rs2_busy = (i_rs2_addr != '0) &&
                        (sb_q[i_rs2_addr] || (b_on_port && (addr_q == i_rs2_addr)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: vector table plus multi-cycle corner sequences.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_ctrl_if bif ();

    regfile_wb_ctrl #(
        .B_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_a_valid     (a_valid),
        .i_a_rd        (a_rd),
        .i_a_data      (a_data),
        .b_if          (bif),
        .i_issue_valid (iss_valid),
        .i_issue_rd    (iss_rd),
        .i_rs1_addr    (rs1),
        .i_rs2_addr    (rs2),
        .o_rs1_busy    (rs1_busy),
        .o_rs2_busy    (rs2_busy),
        .o_rd_wren     (rd_wren),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_v;
        logic [4:0]  a_rd;
        logic [31:0] a_d;
        logic        b_v;
        logic [4:0]  b_rd;
        logic [31:0] b_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_wren;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_valid       = 1'b0;
        a_rd          = '0;
        a_data        = '0;
        bif.i_b_valid = 1'b0;
        bif.i_b_rd    = '0;
        bif.i_b_data  = '0;
        iss_valid     = 1'b0;
        iss_rd        = '0;
        rs1           = '0;
        rs2           = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic e_wren, input logic [4:0] e_addr,
                            input logic [31:0] e_data);
        chk({tag, ".wren"}, 32'(rd_wren), 32'(e_wren));
        chk({tag, ".addr"}, 32'(rd_addr), 32'(e_addr));
        chk({tag, ".data"}, rd_data, e_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // a_v a_rd a_d  b_v b_rd b_d  iss iss_rd rs1 rs2  wren addr data  ready b1 b2
        vecs[0]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd5,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd9, 5'd5,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5,
                     1'b1, 5'd3, 32'h11,       1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9, 5'd5,
                     1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9,
                     1'b1, 5'd9, 32'h99,       1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h77,       1'b0, 5'd0, 5'd9, 5'd3,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3,
                     1'b1, 5'd9, 32'h77,       1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3,
                     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0};

        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_port("reset_hold", 1'b0, 5'd0, 32'h0);
        chk("reset_hold.ready", 32'(bif.o_b_ready), 32'h0);
        rst_n = 1'b1;
        next_cycle();

        // Vector table: registered outputs reflect the previous row, busy reflects this row.
        for (int i = 0; i < 11; i++) begin
            a_valid       = vecs[i].a_v;
            a_rd          = vecs[i].a_rd;
            a_data        = vecs[i].a_d;
            bif.i_b_valid = vecs[i].b_v;
            bif.i_b_rd    = vecs[i].b_rd;
            bif.i_b_data  = vecs[i].b_d;
            iss_valid     = vecs[i].iss_v;
            iss_rd        = vecs[i].iss_rd;
            rs1           = vecs[i].rs1;
            rs2           = vecs[i].rs2;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(rd_wren), 32'(vecs[i].e_wren));
            chk($sformatf("vec%0d.addr", i), 32'(rd_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d.data", i), rd_data, vecs[i].e_data);
            chk($sformatf("vec%0d.ready", i), 32'(bif.o_b_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d.rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].e_b1));
            chk($sformatf("vec%0d.rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].e_b2));
            next_cycle();
        end
        idle_inputs();

        // A priority with B filling the FIFO; fifth B entry must be held off.
        begin
            logic        e_ready [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            logic        e_wren  [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                          1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            logic [4:0]  e_addr  [12] = '{5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3,
                                          5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
            logic [31:0] e_data  [12] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4,
                                          32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h0};
            for (int k = 0; k < 12; k++) begin
                a_valid       = (k < 5);
                a_rd          = 5'd3;
                a_data        = 32'(k);
                bif.i_b_valid = (k < 7);
                bif.i_b_rd    = (k < 4) ? 5'(10 + k) : 5'd14;
                bif.i_b_data  = (k < 4) ? 32'(32'h100 + k) : 32'h104;
                @(negedge clk);
                chk($sformatf("full%0d.ready", k), 32'(bif.o_b_ready), 32'(e_ready[k]));
                chk_port($sformatf("full%0d", k), e_wren[k], e_addr[k], e_data[k]);
                next_cycle();
            end
        end
        idle_inputs();

        // x0 writes and issues: consumed silently, FIFO still drains in order.
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h5;
        bif.i_b_valid = 1'b1; bif.i_b_rd = 5'd0; bif.i_b_data = 32'h6;
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        chk("x0_0.wren", 32'(rd_wren), 32'h0);
        chk("x0_0.rs1_busy", 32'(rs1_busy), 32'h0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("x0_1.wren", 32'(rd_wren), 32'h0);
        chk("x0_1.rs1_busy", 32'(rs1_busy), 32'h0);
        next_cycle();
        bif.i_b_valid = 1'b1; bif.i_b_rd = 5'd4; bif.i_b_data = 32'h44;
        @(negedge clk);
        chk("x0_2.wren", 32'(rd_wren), 32'h0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("x0_3.wren", 32'(rd_wren), 32'h0);
        next_cycle();
        @(negedge clk);
        chk_port("x0_drain", 1'b1, 5'd4, 32'h44);
        next_cycle();
        next_cycle();

        // Asynchronous reset with three B entries queued behind A traffic.
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_rd = 5'd3; a_data = 32'(32'hA0 + k);
            bif.i_b_valid = 1'b1; bif.i_b_rd = 5'(20 + k); bif.i_b_data = 32'(32'h200 + k);
            next_cycle();
        end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_port("async_rst", 1'b0, 5'd0, 32'h0);
        chk("async_rst.ready", 32'(bif.o_b_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_port("rst_held", 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d.wren", k), 32'(rd_wren), 32'h0);
        end
        chk("post_rst.ready", 32'(bif.o_b_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
